// File: rtl/data_sram_responder_pkg.sv
// Shared MMIO decode constants, read-source encoding and a byte-merge helper.
package cdim_mem_pkg;

  localparam logic [15:0] LED_OFF   = 16'hF000;
  localparam logic [15:0] NUM_OFF   = 16'hF004;
  localparam logic [15:0] SW_OFF    = 16'hF008;
  localparam logic [15:0] TIMER_OFF = 16'hE000;

  typedef enum logic [2:0] {
    SRC_RAM,
    SRC_LED,
    SRC_NUM,
    SRC_SW,
    SRC_TIMER,
    SRC_ZERO
  } rd_src_e;

  // Take byte i from nw where be[i] is set, otherwise keep the byte from old.
  function automatic logic [31:0] byte_merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = be[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram_* request/response bus between the memory-access stage and its target.
interface data_sram_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, wen, waddr, wdata, input rdata);
  modport slave  (input en, wen, waddr, wdata, output rdata);
endinterface

// File: rtl/data_sram_responder_bram.sv
// Single-port data RAM, one byte-wide array per lane, registered read, no reset.
module bram_byte_we #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    // Per-lane write with registered read of the same address.
    always_ff @(posedge clk) begin
      if (we[i]) mem[addr] <= wdata[i*8 +: 8];
      if (re)    q         <= mem[addr];
    end

    assign rdata[i*8 +: 8] = q;
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side bus target: local RAM plus an uncached MMIO window (LED, NUM, SWITCH, TIMER).
module data_sram_responder
  import cdim_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [15:0] MMIO_BASE  = 16'h1FAF
) (
  input  logic        clk,
  input  logic        resetn,
  data_sram_if.slave  bus,
  input  logic [7:0]  sw,
  output logic [15:0] led,
  output logic [31:0] num
);

  localparam int STAGES = 1;

  logic              hit, wr, rd;
  logic [15:0]       off;
  rd_src_e           src_d, src_q;
  logic [31:0]       mmio_d, mmio_q;
  logic [31:0]       timer, ram_q, hold_q, rd_word;
  logic [STAGES:0]   vld_pipe;
  logic [3:0]        ram_we;
  logic              unused_lsb;

  // Byte-offset bits never affect decode; misaligned requests are served as aligned.
  assign unused_lsb = ^bus.waddr[1:0];

  // Request decode and MMIO read word, sampled at the request edge.
  always_comb begin
    off    = {bus.waddr[15:2], 2'b00};
    hit    = bus.waddr[31:16] == MMIO_BASE;
    wr     = bus.en && (bus.wen != 4'b0000);
    rd     = bus.en && (bus.wen == 4'b0000);
    src_d  = SRC_RAM;
    mmio_d = '0;
    if (hit) begin
      case (off)
        LED_OFF:   begin src_d = SRC_LED;   mmio_d = {16'h0, led}; end
        NUM_OFF:   begin src_d = SRC_NUM;   mmio_d = num;          end
        SW_OFF:    begin src_d = SRC_SW;    mmio_d = {24'h0, sw};  end
        TIMER_OFF: begin src_d = SRC_TIMER; mmio_d = timer;        end
        default:   begin src_d = SRC_ZERO;  mmio_d = '0;           end
      endcase
    end
    vld_pipe[0] = rd;
    ram_we      = (wr && !hit) ? bus.wen : 4'b0000;
  end

  bram_byte_we #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (rd && !hit),
    .addr  (bus.waddr[ADDR_WIDTH+1:2]),
    .wdata (bus.wdata),
    .rdata (ram_q)
  );

  // Read-valid pipe and captured read source; reset drops any pending read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe[STAGES:1] <= '0;
      src_q              <= SRC_RAM;
      mmio_q             <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (rd) begin
        src_q  <= src_d;
        mmio_q <= mmio_d;
      end
    end
  end

  // MMIO registers; TIMER free-runs and unwritten bytes of a TIMER write follow timer+1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led   <= '0;
      num   <= '0;
      timer <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (wr && hit) begin
        case (off)
          LED_OFF: begin
            if (bus.wen[0]) led[7:0]  <= bus.wdata[7:0];
            if (bus.wen[1]) led[15:8] <= bus.wdata[15:8];
          end
          NUM_OFF:   num   <= byte_merge(num, bus.wdata, bus.wen);
          TIMER_OFF: timer <= byte_merge(timer + 32'd1, bus.wdata, bus.wen);
          default: ;
        endcase
      end
    end
  end

  // Output mux: fresh data the cycle after a read, otherwise the held word.
  always_comb begin
    rd_word   = (src_q == SRC_RAM) ? ram_q : mmio_q;
    bus.rdata = vld_pipe[STAGES] ? rd_word : hold_q;
  end

  // Hold register keeps the last completed read across idles and writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               hold_q <= '0;
    else if (vld_pipe[STAGES]) hold_q <= rd_word;
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed-vector bench for data_sram_responder; inputs change on negedge, outputs checked there.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  sw = 8'h00;
  logic [15:0] led;
  logic [31:0] num;
  int          n_vec = 0;
  int          n_err = 0;

  data_sram_if bus ();

  data_sram_responder dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .sw     (sw),
    .led    (led),
    .num    (num)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one bus cycle and return at the following negedge.
  task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    bus.en    = e;
    bus.wen   = w;
    bus.waddr = a;
    bus.wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    req(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    bus.en = 1'b0; bus.wen = 4'h0; bus.waddr = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_num", num, 32'h0);

    // Release on a negedge: timer counts posedges from here.
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    req(1'b1, 4'h0, 32'h1FAF_E000, 32'h0);
    chk("timer_cyc10", bus.rdata, 32'd10);

    // RAM full and partial writes, write-then-read back to back.
    req(1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF);
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    chk("ram_full", bus.rdata, 32'hDEADBEEF);
    req(1'b1, 4'b0100, 32'h0000_0010, 32'h5A5A5A5A);
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    chk("ram_be2", bus.rdata, 32'hDE5ABEEF);
    req(1'b1, 4'b0011, 32'h0000_0010, 32'h12341234);
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    chk("ram_be01", bus.rdata, 32'hDE5A1234);

    // Aliasing above ADDR_WIDTH and ignored low address bits.
    req(1'b1, 4'hF, 32'h0000_0000, 32'h0000_0001);
    req(1'b1, 4'h0, 32'h0001_0000, 32'h0);
    chk("ram_alias", bus.rdata, 32'h0000_0001);
    req(1'b1, 4'h0, 32'h0000_0012, 32'h0);
    chk("ram_lowbits", bus.rdata, 32'hDE5A1234);

    // MMIO registers.
    req(1'b1, 4'hF, 32'h1FAF_F000, 32'hFFFF_00A5);
    chk("led_wr", {16'h0, led}, 32'h0000_00A5);
    req(1'b1, 4'b1100, 32'h1FAF_F000, 32'hFFFF_FFFF);
    chk("led_hi_be", {16'h0, led}, 32'h0000_00A5);
    req(1'b1, 4'hF, 32'h1FAF_F004, 32'h1234_5678);
    chk("num_wr", num, 32'h1234_5678);
    req(1'b1, 4'h0, 32'h1FAF_F004, 32'h0);
    chk("num_rd", bus.rdata, 32'h1234_5678);
    req(1'b1, 4'h0, 32'h1FAF_F000, 32'h0);
    chk("led_rd", bus.rdata, 32'h0000_00A5);
    sw = 8'h3C;
    req(1'b1, 4'h0, 32'h1FAF_F008, 32'h0);
    chk("sw_rd", bus.rdata, 32'h0000_003C);
    req(1'b1, 4'h0, 32'h1FAF_F100, 32'h0);
    chk("hole_rd", bus.rdata, 32'h0);
    req(1'b1, 4'hF, 32'h1FAF_F100, 32'hFFFF_FFFF);
    chk("hole_wr_led", {16'h0, led}, 32'h0000_00A5);
    chk("hole_wr_num", num, 32'h1234_5678);
    chk("hole_wr_hold", bus.rdata, 32'h0);

    // Timer wrap through zero with back-to-back reads.
    req(1'b1, 4'hF, 32'h1FAF_E000, 32'hFFFF_FFFE);
    req(1'b1, 4'h0, 32'h1FAF_E000, 32'h0);
    chk("timer_fffe", bus.rdata, 32'hFFFF_FFFE);
    req(1'b1, 4'h0, 32'h1FAF_E000, 32'h0);
    chk("timer_ffff", bus.rdata, 32'hFFFF_FFFF);
    req(1'b1, 4'h0, 32'h1FAF_E000, 32'h0);
    chk("timer_wrap", bus.rdata, 32'h0);

    // Partial timer write: unwritten bytes come from timer+1.
    req(1'b1, 4'hF, 32'h1FAF_E000, 32'h0000_01FF);
    req(1'b1, 4'b0001, 32'h1FAF_E000, 32'h0);
    req(1'b1, 4'h0, 32'h1FAF_E000, 32'h0);
    chk("timer_be0", bus.rdata, 32'h0000_0200);

    // Hold across idles and an intervening RAM write.
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    chk("hold_rd", bus.rdata, 32'hDE5A1234);
    repeat (5) idle();
    chk("hold_idle", bus.rdata, 32'hDE5A1234);
    req(1'b1, 4'hF, 32'h0000_0020, 32'hCAFE_F00D);
    chk("hold_wr", bus.rdata, 32'hDE5A1234);

    // Asynchronous reset in the middle of a pending read.
    bus.en = 1'b1; bus.wen = 4'h0; bus.waddr = 32'h0000_0020; bus.wdata = '0;
    #2 resetn = 1'b0;
    #1;
    chk("arst_rdata", bus.rdata, 32'h0);
    chk("arst_led", {16'h0, led}, 32'h0);
    chk("arst_num", num, 32'h0);
    @(negedge clk);
    chk("arst_drop", bus.rdata, 32'h0);
    bus.en = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
